// File: rtl/mac_operand_feeder.sv
// ---------------------------------------------------------------------------
// mac_operand_feeder
//
// Producer side of the MAC PE operand interface. Once started, it walks a
// K-long dot product through two 1-cycle-latency SRAM read ports (A and B).
// It forwards the returned data to a single PE as an a/b operand pair. It
// raises acc_clr_o with the first pair so the PE loads rather than
// accumulates. done_o pulses once the PE accumulator holds the final sum.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous reset, active-low
//   start_i      start a dot product (only honoured while idle)
//   abort_i      synchronous abort, back to idle without done
//   k_len_i      number of operand pairs K (0 allowed), sampled with start
//   a_base_i     first A address, sampled with start
//   b_base_i     first B address, sampled with start
//   b_stride_i   B address increment per element, sampled with start
//   mem_req_o    read request to both SRAMs this cycle
//   a_addr_o     A SRAM read address
//   b_addr_o     B SRAM read address
//   a_rdata_i    A read data, valid the cycle after a request
//   b_rdata_i    B read data, valid the cycle after a request
//   a_o / b_o    operands to the PE (straight from the SRAM read data)
//   a_valid_o    A operand valid
//   b_valid_o    B operand valid (always equal to a_valid_o)
//   acc_clr_o    PE accumulator clear/load, high with the first pair only
//   busy_o       high whenever the feeder is not idle
//   done_o       1-cycle pulse, PE result is final in this cycle
// ---------------------------------------------------------------------------
module mac_operand_feeder #(
  parameter int unsigned DataWidthA = 8,
  parameter int unsigned DataWidthB = 8,
  parameter int unsigned AddrWidth  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [AddrWidth-1:0]  k_len_i,
  input  logic [AddrWidth-1:0]  a_base_i,
  input  logic [AddrWidth-1:0]  b_base_i,
  input  logic [AddrWidth-1:0]  b_stride_i,
  output logic                  mem_req_o,
  output logic [AddrWidth-1:0]  a_addr_o,
  output logic [AddrWidth-1:0]  b_addr_o,
  input  logic [DataWidthA-1:0] a_rdata_i,
  input  logic [DataWidthB-1:0] b_rdata_i,
  output logic [DataWidthA-1:0] a_o,
  output logic [DataWidthB-1:0] b_o,
  output logic                  a_valid_o,
  output logic                  b_valid_o,
  output logic                  acc_clr_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic [AddrWidth-1:0] a_addr_q, a_addr_d;
  logic [AddrWidth-1:0] b_addr_q, b_addr_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [AddrWidth-1:0] k_len_q, k_len_d;
  logic [AddrWidth-1:0] stride_q, stride_d;
  logic                 first_q, first_d;
  logic                 valid_q, valid_d;
  logic                 clr_q, clr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state and next-output logic. cnt_q counts requests issued so far,
  // including the one on mem_req_o this cycle. When it reaches K, the fetch
  // phase ends. first_q marks the cycle carrying the first request. Its data
  // comes back one cycle later, so the valid and clear flags are simply the
  // request flags delayed by one register stage.
  always_comb begin
    state_d  = state_q;
    mem_req_d = 1'b0;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    cnt_d    = cnt_q;
    k_len_d  = k_len_q;
    stride_d = stride_q;
    first_d  = 1'b0;
    valid_d  = mem_req_q;
    clr_d    = mem_req_q & first_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          k_len_d  = k_len_i;
          stride_d = b_stride_i;
          if (k_len_i != '0) begin
            state_d   = StFetch;
            mem_req_d = 1'b1;
            a_addr_d  = a_base_i;
            b_addr_d  = b_base_i;
            cnt_d     = AddrWidth'(1);
            first_d   = 1'b1;
          end else begin
            // An empty dot product skips straight to done without
            // touching memory or the PE.
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        if (cnt_q == k_len_q) begin
          state_d = StDrain;
        end else begin
          mem_req_d = 1'b1;
          a_addr_d  = a_addr_q + AddrWidth'(1);
          b_addr_d  = b_addr_q + stride_q;
          cnt_d     = cnt_q + AddrWidth'(1);
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over everything once a run is underway. Any read already
    // in flight still returns data next cycle. Clearing valid_d here keeps
    // that data from reaching the PE.
    if (abort_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      mem_req_d = 1'b0;
      first_d   = 1'b0;
      valid_d   = 1'b0;
      clr_d     = 1'b0;
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and output registers. Every control output is driven from a
  // flop, so it comes up clean out of reset and stays glitch-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      mem_req_q <= 1'b0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      cnt_q     <= '0;
      k_len_q   <= '0;
      stride_q  <= '0;
      first_q   <= 1'b0;
      valid_q   <= 1'b0;
      clr_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      cnt_q     <= cnt_d;
      k_len_q   <= k_len_d;
      stride_q  <= stride_d;
      first_q   <= first_d;
      valid_q   <= valid_d;
      clr_q     <= clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mem_req_o = mem_req_q;
  assign a_addr_o  = a_addr_q;
  assign b_addr_o  = b_addr_q;
  assign a_o       = a_rdata_i;
  assign b_o       = b_rdata_i;
  assign a_valid_o = valid_q;
  assign b_valid_o = valid_q;
  assign acc_clr_o = clr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_mac_operand_feeder
//
// Drives mac_operand_feeder against two behavioural SRAMs and a behavioural
// PE accumulator. For each run, the expected cycle-by-cycle behaviour comes
// from the run parameters. The expected dot product is summed directly from
// the memory arrays.
// ---------------------------------------------------------------------------
module tb_mac_operand_feeder;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i, abort_i;
  logic [7:0] k_len_i, a_base_i, b_base_i, b_stride_i;
  logic       mem_req_o;
  logic [7:0] a_addr_o, b_addr_o;
  logic [7:0] a_rdata_i, b_rdata_i;
  logic [7:0] a_o, b_o;
  logic       a_valid_o, b_valid_o, acc_clr_o, busy_o, done_o;

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [31:0] pe_acc = '0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cur_t    = 0;
  int          run_k;
  logic [7:0]  run_a, run_b, run_s;
  logic [31:0] run_sum;

  mac_operand_feeder #(
    .DataWidthA(8),
    .DataWidthB(8),
    .AddrWidth (8)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .k_len_i   (k_len_i),
    .a_base_i  (a_base_i),
    .b_base_i  (b_base_i),
    .b_stride_i(b_stride_i),
    .mem_req_o (mem_req_o),
    .a_addr_o  (a_addr_o),
    .b_addr_o  (b_addr_o),
    .a_rdata_i (a_rdata_i),
    .b_rdata_i (b_rdata_i),
    .a_o       (a_o),
    .b_o       (b_o),
    .a_valid_o (a_valid_o),
    .b_valid_o (b_valid_o),
    .acc_clr_o (acc_clr_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  // 1-cycle-latency SRAM read ports.
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      a_rdata_i <= mem_a[a_addr_o];
      b_rdata_i <= mem_b[b_addr_o];
    end
  end

  // PE: load the product on clear, otherwise accumulate.
  always @(posedge clk_i) begin
    if (a_valid_o) begin
      if (acc_clr_o) pe_acc <= 32'(a_o) * 32'(b_o);
      else           pe_acc <= pe_acc + 32'(a_o) * 32'(b_o);
    end
  end

  task checkBit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s t=%0d: observed=%0b expected=%0b", tag, cur_t, obs, exp);
    end
  endtask

  task checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s t=%0d: observed=%0h expected=%0h", tag, cur_t, obs, exp);
    end
  endtask

  function automatic logic [31:0] refSum(input int k, input logic [7:0] ab,
                                         input logic [7:0] bb, input logic [7:0] st);
    logic [31:0] s;
    logic [7:0]  ia, ib;
    s = '0;
    for (int i = 0; i < k; i++) begin
      ia = ab + 8'(i);
      ib = bb + 8'(i * int'(st));
      s  = s + 32'(mem_a[ia]) * 32'(mem_b[ib]);
    end
    return s;
  endfunction

  // Called right after a falling edge; this cycle becomes cycle 0 of a run.
  task applyStimulus(input int k, input logic [7:0] ab, input logic [7:0] bb,
                     input logic [7:0] st);
    start_i    = 1'b1;
    k_len_i    = 8'(k);
    a_base_i   = ab;
    b_base_i   = bb;
    b_stride_i = st;
    run_k      = k;
    run_a      = ab;
    run_b      = bb;
    run_s      = st;
    run_sum    = refSum(k, ab, bb, st);
  endtask

  task nextCycle(input int t);
    @(negedge clk_i);
    cur_t   = t;
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  // Expected outputs in cycle t of the current run.
  task checkOutput(input int t);
    logic       e_req, e_val, e_clr, e_done, e_busy;
    logic [7:0] ea, eb;
    e_req  = (run_k != 0) && (t >= 1) && (t <= run_k);
    e_val  = (run_k != 0) && (t >= 2) && (t <= run_k + 1);
    e_clr  = (run_k != 0) && (t == 2);
    e_done = (run_k == 0) ? (t == 1) : (t == run_k + 2);
    e_busy = (run_k == 0) ? (t == 1) : ((t >= 1) && (t <= run_k + 2));
    checkBit("mem_req", mem_req_o, e_req);
    checkBit("a_valid", a_valid_o, e_val);
    checkBit("b_valid", b_valid_o, e_val);
    checkBit("acc_clr", acc_clr_o, e_clr);
    checkBit("done", done_o, e_done);
    checkBit("busy", busy_o, e_busy);
    if (e_req) begin
      ea = run_a + 8'(t - 1);
      eb = run_b + 8'((t - 1) * int'(run_s));
      checkWord("a_addr", 32'(a_addr_o), 32'(ea));
      checkWord("b_addr", 32'(b_addr_o), 32'(eb));
    end else if ((run_k != 0) && (t > run_k)) begin
      ea = run_a + 8'(run_k - 1);
      eb = run_b + 8'((run_k - 1) * int'(run_s));
      checkWord("a_addr_hold", 32'(a_addr_o), 32'(ea));
      checkWord("b_addr_hold", 32'(b_addr_o), 32'(eb));
    end
    if (e_done && (run_k != 0)) checkWord("pe_sum", pe_acc, run_sum);
  endtask

  // Full run starting in the current cycle; optionally pokes start during done.
  task runChecked(input int k, input logic [7:0] ab, input logic [7:0] bb,
                  input logic [7:0] st, input bit poke_done);
    applyStimulus(k, ab, bb, st);
    for (int t = 1; t <= k + 3; t++) begin
      nextCycle(t);
      checkOutput(t);
      if (poke_done && (t == ((k == 0) ? 1 : k + 2))) begin
        start_i = 1'b1;
        k_len_i = 8'd5;
      end
    end
  endtask

  task checkAllZero(input string tag);
    checkBit({tag, "_req"}, mem_req_o, 1'b0);
    checkBit({tag, "_valid"}, a_valid_o | b_valid_o, 1'b0);
    checkBit({tag, "_clr"}, acc_clr_o, 1'b0);
    checkBit({tag, "_done"}, done_o, 1'b0);
    checkBit({tag, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    k_len_i = '0;
    a_base_i = '0;
    b_base_i = '0;
    b_stride_i = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      mem_a[8'h10 + i] = 8'(i + 1);
      mem_b[8'h20 + i] = 8'd2;
    end

    // Reset state.
    #1;
    checkAllZero("reset");
    checkWord("reset_a_addr", 32'(a_addr_o), 32'h0);
    checkWord("reset_b_addr", 32'(b_addr_o), 32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // K=4 basic run, known sum 20; the next run starts back-to-back.
    runChecked(4, 8'h10, 8'h20, 8'd1, 1'b0);
    checkWord("sum20", pe_acc, 32'd20);

    // K=1: valid and clear together.
    runChecked(1, 8'h00, 8'h00, 8'd1, 1'b0);

    // K=0, with start poked during done (must be ignored).
    runChecked(0, 8'h33, 8'h44, 8'd1, 1'b1);

    // Address wrap.
    runChecked(4, 8'hFE, 8'hF0, 8'd8, 1'b0);

    // Start ignored in done for a nonzero K.
    runChecked(3, 8'h80, 8'h90, 8'd2, 1'b1);

    // K=8: re-start in cycle 3 ignored, abort in cycle 5.
    applyStimulus(8, 8'h30, 8'h40, 8'd3);
    for (int t = 1; t <= 5; t++) begin
      nextCycle(t);
      checkOutput(t);
      if (t == 3) begin
        start_i = 1'b1;
        k_len_i = 8'd3;
        a_base_i = 8'h99;
      end
      if (t == 5) abort_i = 1'b1;
    end
    nextCycle(6);
    checkAllZero("abort");
    runChecked(2, 8'h50, 8'h60, 8'd5, 1'b0);

    // Async reset in mid-fetch.
    applyStimulus(10, 8'h01, 8'h02, 8'd1);
    for (int t = 1; t <= 3; t++) begin
      nextCycle(t);
      checkOutput(t);
    end
    #2 rst_ni = 1'b0;
    #1;
    checkAllZero("midrst");
    checkWord("midrst_a_addr", 32'(a_addr_o), 32'h0);
    checkWord("midrst_b_addr", 32'(b_addr_o), 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    runChecked(2, 8'hC0, 8'hD0, 8'd7, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      runChecked(int'($urandom_range(1, 20)), 8'($urandom), 8'($urandom),
                 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
